// File: rtl/router_lookup_pkg.sv
// rtl/router_lookup_pkg.sv - shared decision/state encodings and log2 helper for the lookup pipeline
package router_lookup_pkg;

    localparam logic [1:0] DEC_DROP    = 2'd0;
    localparam logic [1:0] DEC_TO_CPU  = 2'd1;
    localparam logic [1:0] DEC_FORWARD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_IP = 2'd1,
        ST_OUT     = 2'd2
    } state_e;

    // Ceiling log2, never less than 1 so it can size a register directly.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/router_decision_sequencer_if.sv
// rtl/router_decision_sequencer_if.sv - decision handshake between sequencer and router output stage
interface router_decision_sequencer_if #(
    parameter int PORT_W = 3
);
    logic              decision_vld;
    logic [1:0]        decision;
    logic [PORT_W-1:0] cpu_dst_port;
    logic              decision_err;
    logic              decision_rd;

    modport master (
        output decision_vld, decision, cpu_dst_port, decision_err,
        input  decision_rd
    );

    modport slave (
        input  decision_vld, decision, cpu_dst_port, decision_err,
        output decision_rd
    );
endinterface

// File: rtl/router_decision_rules.sv
// rtl/router_decision_rules.sv - combinational priority mapping of header flags to a decision code
module router_decision_rules
    import router_lookup_pkg::*;
(
    input  logic       timeout_i,
    input  logic       is_arp_pkt_i,
    input  logic       is_ip_pkt_i,
    input  logic       is_for_us_i,
    input  logic       is_broadcast_i,
    input  logic       ip_checksum_is_good_i,
    input  logic       ip_ttl_is_good_i,
    input  logic       ip_hdr_has_options_i,
    output logic [1:0] decision_o
);

    // A timeout short-circuits everything, so stale IP flags are never looked at.
    always_comb begin
        decision_o = DEC_FORWARD;
        if (timeout_i) begin
            decision_o = DEC_DROP;
        end else if (!is_for_us_i && !is_broadcast_i) begin
            decision_o = DEC_DROP;
        end else if (is_broadcast_i || is_arp_pkt_i) begin
            decision_o = DEC_TO_CPU;
        end else if (!is_ip_pkt_i) begin
            decision_o = DEC_DROP;
        end else if (!ip_checksum_is_good_i) begin
            decision_o = DEC_DROP;
        end else if (!ip_ttl_is_good_i || ip_hdr_has_options_i) begin
            decision_o = DEC_TO_CPU;
        end
    end

endmodule

// File: rtl/router_decision_sequencer.sv
// rtl/router_decision_sequencer.sv - pairs eth/IP results per packet, issues pops and a held forwarding decision
module router_decision_sequencer
    import router_lookup_pkg::*;
#(
    parameter int NUM_QUEUES       = 8,
    parameter int NUM_QUEUES_WIDTH = log2(NUM_QUEUES),
    parameter int TIMEOUT          = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        eth_parser_info_vld,
    input  logic                        is_arp_pkt,
    input  logic                        is_ip_pkt,
    input  logic                        is_for_us,
    input  logic                        is_broadcast,
    input  logic [NUM_QUEUES_WIDTH-1:0] mac_dst_port_num,
    output logic                        eth_parser_rd_info,
    input  logic                        ip_checker_info_vld,
    input  logic                        ip_checksum_is_good,
    input  logic                        ip_ttl_is_good,
    input  logic                        ip_hdr_has_options,
    output logic                        rd_ip_checker_info,
    router_decision_sequencer_if.master dec_if,
    output logic [31:0]                 fwd_cnt,
    output logic [31:0]                 cpu_cnt,
    output logic [31:0]                 drop_cnt,
    output logic [31:0]                 timeout_cnt,
    output logic                        sync_err
);

    localparam int            TW         = log2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_e                      state_q, state_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic                        pop_eth, pop_ip, timeout_hit;
    logic [1:0]                  rule_dec;
    logic [1:0]                  decision_q;
    logic [NUM_QUEUES_WIDTH-1:0] cpu_port_q;
    logic                        err_q;
    logic [31:0]                 fwd_cnt_q, cpu_cnt_q, drop_cnt_q, timeout_cnt_q;
    logic                        sync_err_q;

    router_decision_rules u_rules (
        .timeout_i             (timeout_hit),
        .is_arp_pkt_i          (is_arp_pkt),
        .is_ip_pkt_i           (is_ip_pkt),
        .is_for_us_i           (is_for_us),
        .is_broadcast_i        (is_broadcast),
        .ip_checksum_is_good_i (ip_checksum_is_good),
        .ip_ttl_is_good_i      (ip_ttl_is_good),
        .ip_hdr_has_options_i  (ip_hdr_has_options),
        .decision_o            (rule_dec)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pop_eth     = 1'b0;
        pop_ip      = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eth_parser_info_vld && ip_checker_info_vld) begin
                    pop_eth = 1'b1;
                    pop_ip  = 1'b1;
                    state_d = ST_OUT;
                end else if (eth_parser_info_vld) begin
                    timer_d = '0;
                    state_d = ST_WAIT_IP;
                end
            end
            ST_WAIT_IP: begin
                // A late IP result beats the timeout even on the final timer count.
                if (ip_checker_info_vld) begin
                    pop_eth = 1'b1;
                    pop_ip  = 1'b1;
                    state_d = ST_OUT;
                end else if (timer_q == TIMER_LAST) begin
                    pop_eth     = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (dec_if.decision_rd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            decision_q    <= DEC_DROP;
            cpu_port_q    <= '0;
            err_q         <= 1'b0;
            fwd_cnt_q     <= '0;
            cpu_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (pop_eth) begin
                decision_q <= rule_dec;
                cpu_port_q <= mac_dst_port_num + NUM_QUEUES_WIDTH'(1);
                err_q      <= timeout_hit;
                case (rule_dec)
                    DEC_FORWARD: fwd_cnt_q  <= fwd_cnt_q + 32'd1;
                    DEC_TO_CPU:  cpu_cnt_q  <= cpu_cnt_q + 32'd1;
                    default:     drop_cnt_q <= drop_cnt_q + 32'd1;
                endcase
                if (timeout_hit) begin
                    timeout_cnt_q <= timeout_cnt_q + 32'd1;
                    sync_err_q    <= 1'b1;
                end
            end
        end
    end

    // Strobes are combinational, so they are masked while reset is held.
    assign eth_parser_rd_info  = pop_eth && !reset;
    assign rd_ip_checker_info  = pop_ip && !reset;

    assign dec_if.decision_vld = (state_q == ST_OUT);
    assign dec_if.decision     = decision_q;
    assign dec_if.cpu_dst_port = cpu_port_q;
    assign dec_if.decision_err = err_q;

    assign fwd_cnt     = fwd_cnt_q;
    assign cpu_cnt     = cpu_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_router_decision_sequencer.sv
// tb/tb_router_decision_sequencer.sv - directed scoreboard bench for router_decision_sequencer
module tb_router_decision_sequencer;
    import router_lookup_pkg::*;

    localparam int NQ  = 8;
    localparam int NQW = 3;
    localparam int TO  = 64;

    typedef struct {
        logic [1:0]     dec;
        logic [NQW-1:0] port;
        logic           err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           eth_vld, is_arp, is_ip, is_us, is_bc;
    logic [NQW-1:0] mac_port;
    logic           ip_vld, csum, ttl, opts;
    logic           eth_rd, ip_rd;
    logic [31:0]    fwd_cnt, cpu_cnt, drop_cnt, timeout_cnt;
    logic           sync_err;

    router_decision_sequencer_if #(.PORT_W(NQW)) dif ();

    router_decision_sequencer #(
        .NUM_QUEUES       (NQ),
        .NUM_QUEUES_WIDTH (NQW),
        .TIMEOUT          (TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .eth_parser_info_vld (eth_vld),
        .is_arp_pkt          (is_arp),
        .is_ip_pkt           (is_ip),
        .is_for_us           (is_us),
        .is_broadcast        (is_bc),
        .mac_dst_port_num    (mac_port),
        .eth_parser_rd_info  (eth_rd),
        .ip_checker_info_vld (ip_vld),
        .ip_checksum_is_good (csum),
        .ip_ttl_is_good      (ttl),
        .ip_hdr_has_options  (opts),
        .rd_ip_checker_info  (ip_rd),
        .dec_if              (dif.master),
        .fwd_cnt             (fwd_cnt),
        .cpu_cnt             (cpu_cnt),
        .drop_cnt            (drop_cnt),
        .timeout_cnt         (timeout_cnt),
        .sync_err            (sync_err)
    );

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    endtask

    task automatic wait_pop(input int budget, output int at, output logic ipp);
        at  = -1;
        ipp = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (eth_rd) begin
                at  = cyc;
                ipp = ip_rd;
                break;
            end
        end
        check("pop_seen", 32'(at >= 0), 32'd1);
    endtask

    task automatic compare_decision(input string tag);
        exp_t e;
        check({tag, "_vld"}, 32'(dif.decision_vld), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_dec"}, 32'(dif.decision), 32'(e.dec));
            check({tag, "_port"}, 32'(dif.cpu_dst_port), 32'(e.port));
            check({tag, "_err"}, 32'(dif.decision_err), 32'(e.err));
        end
    endtask

    task automatic consume();
        dif.decision_rd = 1'b1;
        @(posedge clk); #1;
        dif.decision_rd = 1'b0;
    endtask

    // Called just after a rising edge; drives one packet and follows it to consumption.
    task automatic run_pkt(input string tag,
                           input logic arp, input logic ip, input logic us, input logic bc,
                           input logic [NQW-1:0] port,
                           input logic ipv, input int ip_delay,
                           input logic c, input logic t, input logic o,
                           input logic [1:0] exp_dec, input logic exp_err,
                           input int exp_lat, input int budget);
        int   start, at;
        logic ipp;
        exp_t e;
        start   = cyc;
        is_arp  = arp; is_ip = ip; is_us = us; is_bc = bc; mac_port = port;
        csum    = c;   ttl = t;    opts = o;
        eth_vld = 1'b1;
        ip_vld  = ipv && (ip_delay == 0);
        if (ipv && ip_delay > 0) begin
            repeat (ip_delay) @(posedge clk);
            #1 ip_vld = 1'b1;
        end
        wait_pop(budget, at, ipp);
        check({tag, "_pop_cycle"}, 32'(at - start), 32'(exp_lat));
        check({tag, "_ip_pop"}, 32'(ipp), 32'(!exp_err));
        e.dec = exp_dec; e.port = port + NQW'(1); e.err = exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        eth_vld = 1'b0;
        ip_vld  = 1'b0;
        @(negedge clk);
        compare_decision(tag);
        consume();
    endtask

    initial begin
        int   at, bad, m;
        logic ipp;
        exp_t e;
        reset = 1'b1;
        eth_vld = 0; is_arp = 0; is_ip = 0; is_us = 0; is_bc = 0; mac_port = '0;
        ip_vld = 0; csum = 0; ttl = 0; opts = 0;
        dif.decision_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_vld", 32'(dif.decision_vld), 32'd0);
        check("rst_dec", 32'(dif.decision), 32'd0);
        check("rst_port", 32'(dif.cpu_dst_port), 32'd0);
        check("rst_err", 32'(dif.decision_err), 32'd0);
        check("rst_strobes", 32'({eth_rd, ip_rd}), 32'd0);
        check("rst_cnts", fwd_cnt | cpu_cnt | drop_cnt | timeout_cnt, 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);

        // IP info alone is never popped
        @(posedge clk); #1 ip_vld = 1'b1;
        @(negedge clk);
        check("ip_alone_no_pop", 32'({eth_rd, ip_rd}), 32'd0);
        @(posedge clk); #1 ip_vld = 1'b0;

        run_pkt("unicast", 0, 1, 1, 0, 3'd2, 1, 0, 1, 1, 0, DEC_FORWARD, 0, 0, 3);
        check("fwd_cnt_1", fwd_cnt, 32'd1);

        run_pkt("arp_bc",  1, 0, 0, 1, 3'd0, 1, 0, 0, 0, 0, DEC_TO_CPU, 0, 0, 3);
        run_pkt("not_us",  0, 1, 0, 0, 3'd2, 1, 0, 1, 1, 0, DEC_DROP,   0, 0, 3);
        run_pkt("bad_csum",0, 1, 1, 0, 3'd4, 1, 0, 0, 1, 0, DEC_DROP,   0, 0, 3);
        run_pkt("ttl_exp", 0, 1, 1, 0, 3'd6, 1, 0, 1, 0, 0, DEC_TO_CPU, 0, 0, 3);
        check("cpu_cnt_2", cpu_cnt, 32'd2);
        check("drop_cnt_2", drop_cnt, 32'd2);

        run_pkt("timeout", 0, 1, 1, 0, 3'd6, 0, 0, 1, 1, 0, DEC_DROP, 1, TO, TO + 4);
        check("timeout_cnt_1", timeout_cnt, 32'd1);
        check("sync_err_set", 32'(sync_err), 32'd1);
        check("drop_cnt_3", drop_cnt, 32'd3);

        run_pkt("ip_at_last", 0, 1, 1, 0, 3'd2, 1, TO, 1, 1, 0, DEC_FORWARD, 0, TO, 4);
        check("timeout_cnt_kept", timeout_cnt, 32'd1);
        check("fwd_cnt_2", fwd_cnt, 32'd2);
        check("sync_err_sticky", 32'(sync_err), 32'd1);

        // Hold the decision with both FIFOs still valid
        is_arp = 0; is_ip = 1; is_us = 1; is_bc = 0; mac_port = 3'd4;
        csum = 1; ttl = 1; opts = 0;
        eth_vld = 1'b1; ip_vld = 1'b1;
        wait_pop(3, at, ipp);
        e.dec = DEC_FORWARD; e.port = 3'd5; e.err = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        @(negedge clk);
        compare_decision("hold_first");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (eth_rd || ip_rd) bad++;
            if (!dif.decision_vld || dif.decision !== DEC_FORWARD || dif.cpu_dst_port !== 3'd5) bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        @(posedge clk); #1;
        m = cyc;
        dif.decision_rd = 1'b1;
        wait_pop(3, at, ipp);
        check("hold_next_pop", 32'(at - m), 32'd1);
        sb.push_back(e);
        @(posedge clk); #1;
        dif.decision_rd = 1'b0;
        @(negedge clk);
        compare_decision("hold_second");
        check("fwd_cnt_4", fwd_cnt, 32'd4);

        // Reset while a decision is held
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_vld", 32'(dif.decision_vld), 32'd0);
        check("midrst_strobes", 32'({eth_rd, ip_rd}), 32'd0);
        check("midrst_cnts", fwd_cnt | cpu_cnt | drop_cnt | timeout_cnt, 32'd0);
        check("midrst_sync_err", 32'(sync_err), 32'd0);
        @(posedge clk); #1;
        eth_vld = 1'b0; ip_vld = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
